// File: rtl/sobel_gradient_pkg.sv
// Shared types and constants for the Sobel gradient stage.
package sobel_gradient_pkg;

  localparam int unsigned PIXW        = 8;
  localparam int unsigned GRADW       = 11;
  localparam int unsigned OUTW        = 9;
  localparam int unsigned SCALE_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Weighted column/row sum a + 2b + c, widened so the gradient difference cannot overflow.
  function automatic logic signed [GRADW-1:0] tri_sum(input logic [PIXW-1:0] a,
                                                      input logic [PIXW-1:0] b,
                                                      input logic [PIXW-1:0] c);
    return signed'(GRADW'(a) + GRADW'({b, 1'b0}) + GRADW'(c));
  endfunction

endpackage

// File: rtl/sobel_gradient_lineBuffer.sv
// One image row of pixel storage; combinational read returns the old word during a write.
module sobel_gradient_lineBuffer
  import sobel_gradient_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [PIXW-1:0] wdata,
  output logic [PIXW-1:0] rdata_c
);

  logic [PIXW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel stage: line buffers, window, and a registered scaled gradient pair.
module sobel_gradient
  import sobel_gradient_pkg::*;
#(
  parameter int unsigned IMGW = 1024,
  parameter int unsigned IMGH = 512,
  parameter int unsigned CNTW = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startEn,
  input  logic [PIXW-1:0]        pixIn,
  input  logic                   pixValid,
  output logic signed [OUTW-1:0] sobelX,
  output logic signed [OUTW-1:0] sobelY,
  output logic                   sobelValid,
  output logic                   started,
  output logic                   frameDone
);

  localparam int unsigned AW = (IMGW > 1) ? $clog2(IMGW) : 1;

  state_t          state;
  logic [CNTW-1:0] col, row;
  logic [PIXW-1:0] win [3][3];
  logic            win_valid, win_last;
  logic [PIXW-1:0] buf0_rd_c, buf1_rd_c;
  logic            accept_c, last_col_c, last_row_c;
  logic signed [GRADW-1:0] gx_c, gy_c;

  assign accept_c   = (state == ST_RUN) && pixValid;
  assign last_col_c = (col == CNTW'(IMGW - 1));
  assign last_row_c = (row == CNTW'(IMGH - 1));

  sobel_gradient_lineBuffer #(.DEPTH(IMGW), .AW(AW)) u_buf0 (
    .clk     (clk),
    .we      (accept_c),
    .addr    (col[AW-1:0]),
    .wdata   (pixIn),
    .rdata_c (buf0_rd_c)
  );

  // Row shift: the row leaving buffer 0 moves down into buffer 1.
  sobel_gradient_lineBuffer #(.DEPTH(IMGW), .AW(AW)) u_buf1 (
    .clk     (clk),
    .we      (accept_c),
    .addr    (col[AW-1:0]),
    .wdata   (buf0_rd_c),
    .rdata_c (buf1_rd_c)
  );

  // Frame control and raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      col     <= '0;
      row     <= '0;
      started <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startEn) begin
            state   <= ST_RUN;
            col     <= '0;
            row     <= '0;
            started <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_c) begin
            if (last_col_c) begin
              col <= '0;
              if (last_row_c) begin
                state   <= ST_DONE;
                started <= 1'b0;
              end else begin
                row <= row + CNTW'(1);
              end
            end else begin
              col <= col + CNTW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          started <= 1'b0;
        end
      endcase
    end
  end

  assign gx_c = tri_sum(win[0][2], win[1][2], win[2][2]) - tri_sum(win[0][0], win[1][0], win[2][0]);
  assign gy_c = tri_sum(win[2][0], win[2][1], win[2][2]) - tri_sum(win[0][0], win[0][1], win[0][2]);

  // Window shift on accept, then one register stage for the scaled gradients.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      sobelX     <= '0;
      sobelY     <= '0;
      sobelValid <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      win_valid <= accept_c && (row >= CNTW'(2)) && (col >= CNTW'(2));
      win_last  <= accept_c && last_col_c && last_row_c;
      if (accept_c) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= buf1_rd_c;
        win[1][2] <= buf0_rd_c;
        win[2][2] <= pixIn;
      end
      sobelValid <= win_valid;
      frameDone  <= win_last;
      if (win_valid) begin
        sobelX <= OUTW'(gx_c >>> SCALE_SHIFT);
        sobelY <= OUTW'(gy_c >>> SCALE_SHIFT);
      end
    end
  end

endmodule
